// File: rtl/uart_tx_fifo_if.sv
// ============================================================================
// Module      : uart_tx_fifo_if
// Description : Bundles the uart_tx_fifo write port, UART launch port and
//               status outputs.
//               master : producer/UART side (drives in_valid, in_byte,
//                        uart_is_transmitting).
//               slave  : the FIFO (drives launch, byte and status outputs).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface uart_tx_fifo_if #(
  parameter int ADDR_W = 4
);
  logic              in_valid;
  logic [7:0]        in_byte;
  logic              uart_transmit;
  logic [7:0]        uart_tx_byte;
  logic              uart_is_transmitting;
  logic              full;
  logic              empty;
  logic [ADDR_W:0]   level;
  logic              overflow;
  logic [7:0]        drop_count;

  modport master (
    output in_valid, in_byte, uart_is_transmitting,
    input  uart_transmit, uart_tx_byte, full, empty, level, overflow, drop_count
  );

  modport slave (
    input  in_valid, in_byte, uart_is_transmitting,
    output uart_transmit, uart_tx_byte, full, empty, level, overflow, drop_count
  );
endinterface

`default_nettype wire

// File: rtl/uart_tx_fifo.sv
// ============================================================================
// Module      : uart_tx_fifo
// Description : Byte FIFO in front of a UART transmitter. Queues write strobes
//               and launches one byte at a time, waiting for the UART busy
//               flag to rise (or a timeout) and fall before the next launch.
// Ports       : clk, rst_n (async, active-low)
//               bus (uart_tx_fifo_if.slave): in_valid/in_byte write port,
//               uart_transmit/uart_tx_byte launch, uart_is_transmitting busy,
//               full/empty/level status, sticky overflow, drop_count.
// Options     : UART_TX_FIFO_DROP_COUNT_EN - build the saturating drop counter;
//               otherwise drop_count is tied to zero.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_tx_fifo #(
  parameter int DEPTH        = 16,
  parameter int ADDR_W       = 4,
  parameter int BUSY_TIMEOUT = 8
) (
  input  wire logic      clk,
  input  wire logic      rst_n,
  uart_tx_fifo_if.slave  bus
);

  localparam int c_TMR_W = $clog2(BUSY_TIMEOUT + 1);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_BUSY = 2'd1,
    WAIT_DONE = 2'd2
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [7:0]          r_mem [DEPTH];
  logic [ADDR_W-1:0]   r_wr_ptr;
  logic [ADDR_W-1:0]   r_rd_ptr;
  logic [ADDR_W:0]     r_level;
  logic [ADDR_W:0]     w_level_nxt;
  logic                r_full;
  logic                r_empty;
  logic                r_overflow;
  logic                r_uart_transmit;
  logic [7:0]          r_tx_byte;
  logic [c_TMR_W-1:0]  r_timer;
  logic                w_push;
  logic                w_drop;
  logic                w_pop;

  // A write while full is dropped even if a pop frees a slot this cycle.
  assign w_push = bus.in_valid && !r_full;
  assign w_drop = bus.in_valid &&  r_full;

  always_comb begin
    w_level_nxt = r_level;
    if (w_push && !w_pop)
      w_level_nxt = r_level + (ADDR_W+1)'(1);
    else if (!w_push && w_pop)
      w_level_nxt = r_level - (ADDR_W+1)'(1);
  end

  // Storage is not reset; pointers and level define what is valid.
  always_ff @(posedge clk) begin
    if (w_push)
      r_mem[r_wr_ptr] <= bus.in_byte;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_level    <= '0;
      r_full     <= 1'b0;
      r_empty    <= 1'b1;
      r_overflow <= 1'b0;
    end else begin
      if (w_push)
        r_wr_ptr <= r_wr_ptr + ADDR_W'(1);
      if (w_pop)
        r_rd_ptr <= r_rd_ptr + ADDR_W'(1);
      r_level <= w_level_nxt;
      r_full  <= (w_level_nxt == (ADDR_W+1)'(DEPTH));
      r_empty <= (w_level_nxt == '0);
      if (w_drop)
        r_overflow <= 1'b1;
    end
  end

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_state <= IDLE;
    else
      r_state <= w_state_nxt;
  end

  // FSM next state; w_pop is the launch decision
  always_comb begin
    w_state_nxt = r_state;
    w_pop       = 1'b0;
    case (r_state)
      IDLE: begin
        if (!r_empty && !bus.uart_is_transmitting) begin
          w_pop       = 1'b1;
          w_state_nxt = WAIT_BUSY;
        end
      end
      WAIT_BUSY: begin
        // The UART never reported busy: treat the byte as sent and move on.
        if (bus.uart_is_transmitting)
          w_state_nxt = WAIT_DONE;
        else if (r_timer == c_TMR_W'(BUSY_TIMEOUT - 1))
          w_state_nxt = IDLE;
      end
      WAIT_DONE: begin
        if (!bus.uart_is_transmitting)
          w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Timer counts cycles spent in WAIT_BUSY; zero on the first such cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_timer <= '0;
    else if (r_state != WAIT_BUSY)
      r_timer <= '0;
    else
      r_timer <= r_timer + c_TMR_W'(1);
  end

  // Launch pulse and byte are registered; the byte holds until the next pop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_uart_transmit <= 1'b0;
      r_tx_byte       <= 8'd0;
    end else begin
      r_uart_transmit <= w_pop;
      if (w_pop)
        r_tx_byte <= r_mem[r_rd_ptr];
    end
  end

`ifdef UART_TX_FIFO_DROP_COUNT_EN
  logic [7:0] r_drop_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_drop_count <= 8'd0;
    else if (w_drop && (r_drop_count != 8'hFF))
      r_drop_count <= r_drop_count + 8'd1;
  end

  assign bus.drop_count = r_drop_count;
`else
  assign bus.drop_count = 8'd0;
`endif

  assign bus.uart_transmit = r_uart_transmit;
  assign bus.uart_tx_byte  = r_tx_byte;
  assign bus.full          = r_full;
  assign bus.empty         = r_empty;
  assign bus.level         = r_level;
  assign bus.overflow      = r_overflow;

endmodule

`default_nettype wire

// File: tb/tb_uart_tx_fifo.sv
// ============================================================================
// Module      : tb_uart_tx_fifo
// Description : Directed self-checking bench for uart_tx_fifo (DEPTH=16,
//               BUSY_TIMEOUT=8). Includes a simple UART busy model that holds
//               busy for three cycles after each launch.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_uart_tx_fifo;

  logic clk;
  logic rst_n;
  logic auto_en;
  logic model_busy;
  logic manual_busy;

  int n_total;
  int n_bad;
  int cyc;
  int long_pulse;
  int acc;
  logic prev_tx;

  logic [7:0] cap[$];
  int         cap_cyc[$];
  logic [7:0] exp_q[$];

`ifdef UART_TX_FIFO_DROP_COUNT_EN
  localparam logic [7:0] c_DROP_EXP = 8'd1;
`else
  localparam logic [7:0] c_DROP_EXP = 8'd0;
`endif

  uart_tx_fifo_if #(.ADDR_W(4)) bus ();

  uart_tx_fifo #(
    .DEPTH        (16),
    .ADDR_W       (4),
    .BUSY_TIMEOUT (8)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  assign bus.uart_is_transmitting = auto_en ? model_busy : manual_busy;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One write per cycle; level checked against accepted writes minus launches.
  task automatic write_chk(input logic [7:0] b);
    bus.in_valid = 1'b1;
    bus.in_byte  = b;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    acc++;
    exp_q.push_back(b);
    @(negedge clk);
    #1;
    check("level_track", 32'(bus.level), 32'(acc - cap.size()));
  endtask

  task automatic wait_caps(input int n, input int budget, input bit lvl_chk, input string tag);
    int k;
    k = 0;
    while (cap.size() < n && k < budget) begin
      @(negedge clk);
      #1;
      k++;
      if (lvl_chk)
        check("level_drain", 32'(bus.level), 32'(acc - cap.size()));
    end
    check(tag, 32'(cap.size()), 32'(n));
  endtask

  // Launch monitor
  initial begin
    cyc        = 0;
    long_pulse = 0;
    prev_tx    = 1'b0;
    forever begin
      @(negedge clk);
      cyc++;
      if (bus.uart_transmit === 1'b1) begin
        cap.push_back(bus.uart_tx_byte);
        cap_cyc.push_back(cyc);
        if (prev_tx)
          long_pulse++;
      end
      prev_tx = bus.uart_transmit;
    end
  end

  // UART busy model
  initial begin
    model_busy = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (auto_en && bus.uart_transmit) begin
        model_busy = 1'b1;
        repeat (3) begin
          @(posedge clk);
          #1;
        end
        model_busy = 1'b0;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    n_total      = 0;
    n_bad        = 0;
    acc          = 0;
    rst_n        = 1'b0;
    auto_en      = 1'b0;
    manual_busy  = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_byte  = 8'd0;

    // Reset state
    repeat (2) tick();
    check("rst_empty", 32'(bus.empty), 1);
    check("rst_full", 32'(bus.full), 0);
    check("rst_level", 32'(bus.level), 0);
    check("rst_ovf", 32'(bus.overflow), 0);
    check("rst_drop", 32'(bus.drop_count), 0);
    check("rst_tx", 32'(bus.uart_transmit), 0);
    check("rst_byte", 32'(bus.uart_tx_byte), 0);
    rst_n = 1'b1;
    repeat (2) tick();

    // Single byte, UART idle
    cap.delete();
    bus.in_valid = 1'b1;
    bus.in_byte  = 8'hA5;
    tick();
    bus.in_valid = 1'b0;
    check("sb_level1", 32'(bus.level), 1);
    check("sb_empty0", 32'(bus.empty), 0);
    check("sb_tx_early", 32'(bus.uart_transmit), 0);
    tick();
    check("sb_tx", 32'(bus.uart_transmit), 1);
    check("sb_byte", 32'(bus.uart_tx_byte), 32'h A5);
    check("sb_level0", 32'(bus.level), 0);
    check("sb_empty1", 32'(bus.empty), 1);
    manual_busy = 1'b1;
    tick();
    check("sb_tx_one", 32'(bus.uart_transmit), 0);
    check("sb_byte_hold", 32'(bus.uart_tx_byte), 32'h A5);
    repeat (3) tick();
    manual_busy = 1'b0;
    repeat (4) tick();
    check("sb_count", 32'(cap.size()), 1);

    // Burst to full, then overflow
    cap.delete();
    manual_busy = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      bus.in_valid = 1'b1;
      bus.in_byte  = 8'(i);
      tick();
      if (i == 15) begin
        check("bu_level15", 32'(bus.level), 15);
        check("bu_full15", 32'(bus.full), 0);
      end
    end
    check("bu_full", 32'(bus.full), 1);
    check("bu_level16", 32'(bus.level), 16);
    check("bu_ovf0", 32'(bus.overflow), 0);
    bus.in_byte = 8'h11;
    tick();
    bus.in_valid = 1'b0;
    check("ov_flag", 32'(bus.overflow), 1);
    check("ov_drop", 32'(bus.drop_count), 32'(c_DROP_EXP));
    check("ov_level", 32'(bus.level), 16);
    check("ov_nolaunch", 32'(cap.size()), 0);
    manual_busy = 1'b0;
    auto_en     = 1'b1;
    wait_caps(16, 300, 1'b0, "bu_drain_cnt");
    for (int i = 0; i < 16; i++)
      check("bu_order", 32'(cap[i]), 32'(i + 1));
    repeat (20) tick();
    check("bu_no17", 32'(cap.size()), 16);
    check("bu_empty", 32'(bus.empty), 1);
    check("ov_sticky", 32'(bus.overflow), 1);
    check("pulse_width", 32'(long_pulse), 0);
    auto_en = 1'b0;

    // Busy timeout
    cap.delete();
    cap_cyc.delete();
    manual_busy  = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_byte  = 8'h3C;
    tick();
    bus.in_byte  = 8'h3D;
    tick();
    bus.in_valid = 1'b0;
    check("to_level", 32'(bus.level), 1);
    wait_caps(2, 40, 1'b0, "to_cnt");
    check("to_b0", 32'(cap[0]), 32'h3C);
    check("to_b1", 32'(cap[1]), 32'h3D);
    check("to_gap", 32'(cap_cyc[1] - cap_cyc[0]), 9);
    repeat (20) tick();
    check("to_no_more", 32'(cap.size()), 2);
    check("to_ovf_sticky", 32'(bus.overflow), 1);

    // Mid-burst reset
    cap.delete();
    manual_busy = 1'b1;
    for (int i = 0; i < 5; i++) begin
      bus.in_valid = 1'b1;
      bus.in_byte  = 8'(8'h60 + i);
      tick();
    end
    bus.in_valid = 1'b0;
    check("mr_level5", 32'(bus.level), 5);
    rst_n = 1'b0;
    #1;
    check("mr_empty", 32'(bus.empty), 1);
    check("mr_level", 32'(bus.level), 0);
    check("mr_ovf", 32'(bus.overflow), 0);
    check("mr_drop", 32'(bus.drop_count), 0);
    check("mr_byte", 32'(bus.uart_tx_byte), 0);
    tick();
    rst_n       = 1'b1;
    manual_busy = 1'b0;
    repeat (20) tick();
    check("mr_no_tx", 32'(cap.size()), 0);
    check("mr_empty_after", 32'(bus.empty), 1);

    // Wrap and simultaneous push/pop
    cap.delete();
    exp_q.delete();
    acc         = 0;
    manual_busy = 1'b1;
    @(negedge clk);
    #1;
    for (int i = 0; i < 12; i++)
      write_chk(8'(8'h40 + i));
    manual_busy = 1'b0;
    auto_en     = 1'b1;
    wait_caps(8, 100, 1'b1, "wr_drain8");
    for (int i = 0; i < 10; i++)
      write_chk(8'(8'h80 + i));
    wait_caps(22, 400, 1'b1, "wr_total");
    for (int i = 0; i < 22; i++)
      check("wr_order", 32'(cap[i]), 32'(exp_q[i]));
    repeat (10) tick();
    check("wr_level0", 32'(bus.level), 0);
    check("wr_empty", 32'(bus.empty), 1);
    check("wr_count", 32'(cap.size()), 22);
    check("pulse_width2", 32'(long_pulse), 0);
    auto_en = 1'b0;

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
